// File: rtl/unary_add_host.sv
// Transaction controller for the 1-4-14 unary adder: streams two binary operands
// as unary pulse trains, then counts the adder's output pulses back into binary.
module unary_add_host #(
  parameter int unsigned OP_W  = 4,
  parameter int unsigned MOD   = 15,
  parameter int unsigned SUM_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [OP_W-1:0]  op_a,
  input  logic [OP_W-1:0]  op_b,
  output logic             busy,
  output logic             done,
  output logic [SUM_W-1:0] sum,
  output logic             carry,
  output logic             err,
  output logic             en,
  output logic             read_or_write,
  output logic             A,
  output logic             B,
  input  logic             dout,
  input  logic             C
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_READ   = 3'd1,
    S_SETTLE = 3'd2,
    S_WRITE  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic [OP_W-1:0]  opa_q, opb_q, nmax_q, k_q, ones_q;
  logic             wfirst_q, carry_q, err_q;
  logic [SUM_W-1:0] sum_q;
  logic             en_q, rw_q, a_q, b_q, busy_q, done_q;

  logic [OP_W-1:0]  a_src, b_src, n_src, k_d;
  logic             bad_op, overrun;
  logic             en_d, rw_d, a_d, b_d, busy_d, done_d;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; in IDLE the operand sources come straight from the ports
  always_comb begin
    state_d = state_q;
    bad_op  = 1'b0;
    overrun = 1'b0;
    a_src   = opa_q;
    b_src   = opb_q;
    n_src   = nmax_q;
    k_d     = k_q;
    case (state_q)
      S_IDLE: begin
        a_src = op_a;
        b_src = op_b;
        n_src = (op_a > op_b) ? op_a : op_b;
        k_d   = '0;
        if (start) begin
          if (({1'b0, op_a} >= (OP_W+1)'(MOD)) || ({1'b0, op_b} >= (OP_W+1)'(MOD))) begin
            bad_op  = 1'b1;
            state_d = S_DONE;
          end else if (n_src == '0) begin
            state_d = S_SETTLE;
          end else begin
            state_d = S_READ;
          end
        end
      end
      S_READ: begin
        k_d = k_q + OP_W'(1);
        if (k_d == nmax_q) state_d = S_SETTLE;
      end
      S_SETTLE: state_d = S_WRITE;
      S_WRITE: begin
        if (!wfirst_q) begin
          if (!dout) begin
            state_d = S_DONE;
          end else if (ones_q == OP_W'(MOD - 1)) begin
            overrun = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic: values the registered outputs take in the next cycle
  always_comb begin
    en_d   = (state_d == S_READ) || (state_d == S_SETTLE) || (state_d == S_WRITE);
    rw_d   = (state_d == S_WRITE);
    a_d    = (state_d == S_READ) && (k_d < a_src);
    b_d    = (state_d == S_READ) && (k_d < b_src);
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      en_q   <= 1'b0;
      rw_q   <= 1'b0;
      a_q    <= 1'b0;
      b_q    <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      en_q   <= en_d;
      rw_q   <= rw_d;
      a_q    <= a_d;
      b_q    <= b_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  // Datapath: operand capture, carry accumulation, pulse counting, result
  always_ff @(posedge clk) begin
    if (rst) begin
      opa_q    <= '0;
      opb_q    <= '0;
      nmax_q   <= '0;
      k_q      <= '0;
      ones_q   <= '0;
      wfirst_q <= 1'b0;
      carry_q  <= 1'b0;
      err_q    <= 1'b0;
      sum_q    <= '0;
    end else begin
      k_q <= k_d;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            opa_q   <= op_a;
            opb_q   <= op_b;
            nmax_q  <= n_src;
            ones_q  <= '0;
            carry_q <= 1'b0;
            err_q   <= bad_op;
            if (bad_op) sum_q <= '0;
          end
        end
        // C lags the driven pulse by one cycle, so READ k=0 sees a stale value
        S_READ: begin
          if (k_q != '0) carry_q <= carry_q | C;
        end
        S_SETTLE: begin
          if (nmax_q != '0) carry_q <= carry_q | C;
          wfirst_q <= 1'b1;
        end
        S_WRITE: begin
          wfirst_q <= 1'b0;
          if (!wfirst_q && dout && !overrun) ones_q <= ones_q + OP_W'(1);
          if (state_d == S_DONE) begin
            err_q <= overrun;
            if (overrun)      sum_q <= '0;
            else if (carry_q) sum_q <= SUM_W'(MOD) + SUM_W'(ones_q);
            else              sum_q <= SUM_W'(ones_q);
          end
        end
        default: ;
      endcase
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign sum           = sum_q;
  assign carry         = carry_q;
  assign err           = err_q;
  assign en            = en_q;
  assign read_or_write = rw_q;
  assign A             = a_q;
  assign B             = b_q;

endmodule

// File: tb/tb_unary_add_host.sv
// Directed bench for unary_add_host with a behavioural mod-15 unary adder stub.
module tb_unary_add_host;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] op_a, op_b;
  logic       busy, done, carry, err, en, rw, a_p, b_p;
  logic [4:0] sum;
  logic       stub_dout, stub_c;

  int n_tests = 0;
  int n_fail  = 0;
  int rd_cnt = 0, en_cnt = 0, a_cnt = 0, b_cnt = 0;
  int stub_cnt;

  always #5 clk = ~clk;

  unary_add_host dut (
    .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b),
    .busy(busy), .done(done), .sum(sum), .carry(carry), .err(err),
    .en(en), .read_or_write(rw), .A(a_p), .B(b_p),
    .dout(stub_dout), .C(stub_c)
  );

  // Adder stub: accumulates unary pulses mod 15 in read, drains count as pulses in write
  always @(posedge clk) begin
    if (rst) begin
      stub_cnt  <= 0;
      stub_c    <= 1'b0;
      stub_dout <= 1'b0;
    end else if (en && !rw) begin
      stub_dout <= 1'b0;
      if (stub_cnt + int'(a_p) + int'(b_p) >= 15) begin
        stub_cnt <= stub_cnt + int'(a_p) + int'(b_p) - 15;
        stub_c   <= 1'b1;
      end else begin
        stub_cnt <= stub_cnt + int'(a_p) + int'(b_p);
        stub_c   <= 1'b0;
      end
    end else if (en && rw) begin
      stub_c <= 1'b0;
      if (stub_cnt > 0) begin
        stub_dout <= 1'b1;
        stub_cnt  <= stub_cnt - 1;
      end else begin
        stub_dout <= 1'b0;
      end
    end else begin
      stub_c    <= 1'b0;
      stub_dout <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (en && !rw)        rd_cnt++;
      if (en)               en_cnt++;
      if (en && !rw && a_p) a_cnt++;
      if (en && !rw && b_p) b_cnt++;
    end
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic run_txn(input string name, input int a, input int b,
                         input int e_sum, input int e_carry, input int e_err,
                         input int e_cyc, input int e_rd, input int e_a, input int e_b,
                         input bit hold, input bit poke);
    int rd0, en0, a0, b0, cyc;
    bit got;
    rd0 = rd_cnt; en0 = en_cnt; a0 = a_cnt; b0 = b_cnt;
    cyc = 0; got = 1'b0;
    start = 1'b1; op_a = 4'(a); op_b = 4'(b);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1 && !hold) start = 1'b0;
      if (poke && cyc == 3) begin start = 1'b1; op_a = 4'd1; op_b = 4'd1; end
      if (poke && cyc == 4) start = 1'b0;
      if (done) begin got = 1'b1; break; end
    end
    check({name, ".done_seen"}, int'(got), 1);
    check({name, ".latency"}, cyc, e_cyc);
    check({name, ".sum"}, int'(sum), e_sum);
    check({name, ".carry"}, int'(carry), e_carry);
    check({name, ".err"}, int'(err), e_err);
    check({name, ".read_cycles"}, rd_cnt - rd0, e_rd);
    check({name, ".a_pulses"}, a_cnt - a0, e_a);
    check({name, ".b_pulses"}, b_cnt - b0, e_b);
    if (e_rd == 0) check({name, ".en_cycles"}, en_cnt - en0, 0);
    @(negedge clk);
    start = 1'b0;
    check({name, ".done_pulse"}, int'(done), 0);
    check({name, ".busy_after"}, int'(busy), 0);
    repeat (3) @(negedge clk);
    check({name, ".busy_idle"}, int'(busy), 0);
    check({name, ".sum_hold"}, int'(sum), e_sum);
  endtask

  initial begin
    int dn;
    bit seen_w;
    rst = 1'b1; start = 1'b0; op_a = 4'd0; op_b = 4'd0;
    repeat (2) @(negedge clk);
    check("rst.busy", int'(busy), 0);
    check("rst.done", int'(done), 0);
    check("rst.en", int'(en), 0);
    check("rst.rw", int'(rw), 0);
    check("rst.sum", int'(sum), 0);
    rst = 1'b0;
    @(negedge clk);

    run_txn("t3p4",   3,  4,  7, 0, 0, 15,  5,  3,  4, 1'b0, 1'b1);
    run_txn("t9p9",   9,  9, 18, 1, 0, 16, 10,  9,  9, 1'b0, 1'b0);
    run_txn("t14p14", 14, 14, 28, 1, 0, 31, 15, 14, 14, 1'b0, 1'b0);
    run_txn("t0p0",   0,  0,  0, 0, 0,  4,  1,  0,  0, 1'b0, 1'b0);
    run_txn("bad15",  15, 2,  0, 0, 1,  1,  0,  0,  0, 1'b1, 1'b0);
    run_txn("bad_b",  1, 15,  0, 0, 1,  1,  0,  0,  0, 1'b0, 1'b0);

    // Reset in the middle of the write phase
    start = 1'b1; op_a = 4'd9; op_b = 4'd9;
    seen_w = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (rw) begin seen_w = 1'b1; break; end
    end
    check("rstw.reached_write", int'(seen_w), 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rstw.en", int'(en), 0);
    check("rstw.rw", int'(rw), 0);
    check("rstw.A", int'(a_p), 0);
    check("rstw.B", int'(b_p), 0);
    check("rstw.busy", int'(busy), 0);
    check("rstw.done", int'(done), 0);
    check("rstw.carry", int'(carry), 0);
    check("rstw.err", int'(err), 0);
    check("rstw.sum", int'(sum), 0);
    rst = 1'b0;
    dn = 0;
    repeat (5) begin
      @(negedge clk);
      if (done) dn++;
    end
    check("rstw.no_done", dn, 0);
    run_txn("t5p6", 5, 6, 11, 0, 0, 21, 7, 5, 6, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
